// File: rtl/soc_pkg.sv
// Shared SoC definitions: RV32 opcode/funct3 constants plus the LSU state and
// access-size encodings.
package soc_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_ILL  = 2'b11
  } mem_size_e;

  // Illegal size encoding, or an access that is not naturally aligned.
  function automatic logic lsu_illegal(input logic [1:0] size, input logic [1:0] off);
    case (mem_size_e'(size))
      MEM_BYTE: return 1'b0;
      MEM_HALF: return off[0];
      MEM_WORD: return off != 2'b00;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: shifts store data/strobes into place and extracts and
// extends the addressed lane of a load word.
module lsu_align
  import soc_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int STRB_W = WORD_W/8
) (
  input  logic [1:0]        off,
  input  logic [1:0]        size,
  input  logic              is_sign,
  input  logic [WORD_W-1:0] st_data,
  input  logic [WORD_W-1:0] ld_raw,
  output logic [WORD_W-1:0] st_shifted,
  output logic [STRB_W-1:0] st_strb,
  output logic [WORD_W-1:0] ld_ext
);

  logic [STRB_W-1:0] mask;
  logic [WORD_W-1:0] ld_sh;

  always_comb begin
    st_shifted = st_data << {off, 3'b000};
    ld_sh      = ld_raw >> {off, 3'b000};
    case (mem_size_e'(size))
      MEM_BYTE: begin
        mask   = STRB_W'(1);
        ld_ext = {{(WORD_W-8){is_sign & ld_sh[7]}}, ld_sh[7:0]};
      end
      MEM_HALF: begin
        mask   = STRB_W'(3);
        ld_ext = {{(WORD_W-16){is_sign & ld_sh[15]}}, ld_sh[15:0]};
      end
      default: begin
        mask   = '1;
        ld_ext = ld_sh;
      end
    endcase
    st_strb = mask << off;
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one memory operation at a time over a valid/ready request
// channel and a valid-only response channel.
module lsu
  import soc_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int STRB_W = WORD_W/8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [1:0]        mem_size,
  input  logic              is_mem_sign,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rdata,
  output logic              misaligned,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [WORD_W-1:0] dmem_req_addr,
  output logic [WORD_W-1:0] dmem_req_wdata,
  output logic [STRB_W-1:0] dmem_req_wstrb,
  input  logic              dmem_resp_valid,
  input  logic [WORD_W-1:0] dmem_resp_data
);

  lsu_state_e        state;
  logic [1:0]        op_off, op_size;
  logic              op_sign;
  logic [1:0]        al_off, al_size;
  logic              al_sign;
  logic [WORD_W-1:0] st_shifted, ld_ext;
  logic [STRB_W-1:0] st_strb;

  // One aligner serves both directions: live operands in IDLE build the
  // request, latched operands in WAIT steer the response.
  always_comb begin
    al_off  = op_off;
    al_size = op_size;
    al_sign = op_sign;
    if (state == LSU_IDLE) begin
      al_off  = addr[1:0];
      al_size = mem_size;
      al_sign = is_mem_sign;
    end
  end

  lsu_align #(.WORD_W(WORD_W), .STRB_W(STRB_W)) u_align (
    .off        (al_off),
    .size       (al_size),
    .is_sign    (al_sign),
    .st_data    (wdata),
    .ld_raw     (dmem_resp_data),
    .st_shifted (st_shifted),
    .st_strb    (st_strb),
    .ld_ext     (ld_ext)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= LSU_IDLE;
      op_off         <= '0;
      op_size        <= '0;
      op_sign        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      misaligned     <= 1'b0;
      rdata          <= '0;
      dmem_req_valid <= 1'b0;
      dmem_req_we    <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_wdata <= '0;
      dmem_req_wstrb <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        LSU_IDLE: if (start) begin
          op_off  <= addr[1:0];
          op_size <= mem_size;
          op_sign <= is_mem_sign;
          busy    <= 1'b1;
          if (lsu_illegal(mem_size, addr[1:0])) begin
            state      <= LSU_DONE;
            done       <= 1'b1;
            misaligned <= 1'b1;
          end else begin
            state          <= LSU_REQ;
            dmem_req_valid <= 1'b1;
            dmem_req_we    <= is_store;
            dmem_req_addr  <= {addr[WORD_W-1:2], 2'b00};
            dmem_req_wdata <= st_shifted;
            dmem_req_wstrb <= st_strb;
          end
        end
        LSU_REQ: if (dmem_req_ready) begin
          dmem_req_valid <= 1'b0;
          if (dmem_req_we) begin
            state      <= LSU_DONE;
            done       <= 1'b1;
            misaligned <= 1'b0;
          end else begin
            state <= LSU_WAIT;
          end
        end
        LSU_WAIT: if (dmem_resp_valid) begin
          rdata      <= ld_ext;
          state      <= LSU_DONE;
          done       <= 1'b1;
          misaligned <= 1'b0;
        end
        default: begin
          state <= LSU_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a vector table for single operations plus
// backpressure, busy-start and mid-operation reset sequences.
module tb_lsu;

  logic        clock, reset, start, is_store, is_mem_sign;
  logic [31:0] addr, wdata, rdata, dmem_req_addr, dmem_req_wdata, dmem_resp_data;
  logic [1:0]  mem_size;
  logic        busy, done, misaligned;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we, dmem_resp_valid;
  logic [3:0]  dmem_req_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  lsu #(.WORD_W(32), .STRB_W(4)) dut (
    .clock(clock), .reset(reset), .start(start), .is_store(is_store),
    .addr(addr), .wdata(wdata), .mem_size(mem_size), .is_mem_sign(is_mem_sign),
    .busy(busy), .done(done), .rdata(rdata), .misaligned(misaligned),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] resp;
    logic [31:0] ex_rd;
    logic        ex_mis;
    logic [31:0] ex_addr;
    logic [3:0]  ex_strb;
    logic [31:0] ex_wd;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input vec_t v, input string tag);
    logic seen_req, got;
    int   cyc;
    @(negedge clock);
    is_store = v.st; addr = v.a; wdata = v.wd; mem_size = v.sz;
    is_mem_sign = v.sg; dmem_resp_data = v.resp; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    seen_req = 1'b0; got = 1'b0; cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (dmem_req_valid && !seen_req) begin
        seen_req = 1'b1;
        chk({tag, "_req_addr"},  dmem_req_addr,  v.ex_addr);
        chk({tag, "_req_we"},    32'(dmem_req_we), 32'(v.st));
        chk({tag, "_req_wstrb"}, 32'(dmem_req_wstrb), 32'(v.ex_strb));
        chk({tag, "_req_wdata"}, dmem_req_wdata, v.ex_wd);
      end
      if (done) begin
        got = 1'b1;
        chk({tag, "_latency"},    cyc, v.lat);
        chk({tag, "_rdata"},      rdata, v.ex_rd);
        chk({tag, "_misaligned"}, 32'(misaligned), 32'(v.ex_mis));
      end
    end
    if (!got) chk({tag, "_done_timeout"}, 32'(got), 32'd1);
    chk({tag, "_req_issued"}, 32'(seen_req), 32'(!v.ex_mis));
    @(negedge clock);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"},      32'(busy), 32'd0);
    chk({tag, "_rdata_hold"},     rdata, v.ex_rd);
  endtask

  initial begin
    logic got;
    int   cyc;
    // st, addr, wdata, size, sign, resp, rdata, mis, req_addr, strb, req_wdata, latency
    vecs[0]  = '{1'b0, 32'h0000_1003, 32'h0000_00CD, 2'b00, 1'b1, 32'h80FF_FFFF, 32'hFFFF_FF80, 1'b0, 32'h0000_1000, 4'b1000, 32'hCD00_0000, 3};
    vecs[1]  = '{1'b0, 32'h0000_2002, 32'h0000_0000, 2'b01, 1'b0, 32'hBEEF_1234, 32'h0000_BEEF, 1'b0, 32'h0000_2000, 4'b1100, 32'h0000_0000, 3};
    vecs[2]  = '{1'b1, 32'h0000_3001, 32'h0000_00AB, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0000_BEEF, 1'b0, 32'h0000_3000, 4'b0010, 32'h0000_AB00, 2};
    vecs[3]  = '{1'b0, 32'h0000_4002, 32'h0000_0000, 2'b10, 1'b0, 32'h1111_1111, 32'h0000_BEEF, 1'b1, 32'h0,         4'b0000, 32'h0,         1};
    vecs[4]  = '{1'b0, 32'h0000_5000, 32'h0000_0000, 2'b10, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'h0000_5000, 4'b1111, 32'h0000_0000, 3};
    vecs[5]  = '{1'b0, 32'h0000_6000, 32'h0000_0000, 2'b01, 1'b1, 32'h1234_8765, 32'hFFFF_8765, 1'b0, 32'h0000_6000, 4'b0011, 32'h0000_0000, 3};
    vecs[6]  = '{1'b0, 32'h0000_7001, 32'h0000_0000, 2'b00, 1'b0, 32'h0000_F000, 32'h0000_00F0, 1'b0, 32'h0000_7000, 4'b0010, 32'h0000_0000, 3};
    vecs[7]  = '{1'b1, 32'h0000_8002, 32'h0000_CAFE, 2'b01, 1'b0, 32'h5555_5555, 32'h0000_00F0, 1'b0, 32'h0000_8000, 4'b1100, 32'hCAFE_0000, 2};
    vecs[8]  = '{1'b1, 32'h0000_9000, 32'h1234_5678, 2'b10, 1'b0, 32'h5555_5555, 32'h0000_00F0, 1'b0, 32'h0000_9000, 4'b1111, 32'h1234_5678, 2};
    vecs[9]  = '{1'b0, 32'h0000_A000, 32'h0000_0000, 2'b11, 1'b0, 32'h2222_2222, 32'h0000_00F0, 1'b1, 32'h0,         4'b0000, 32'h0,         1};
    vecs[10] = '{1'b1, 32'h0000_B001, 32'h0000_7777, 2'b01, 1'b0, 32'h3333_3333, 32'h0000_00F0, 1'b1, 32'h0,         4'b0000, 32'h0,         1};
    vecs[11] = '{1'b0, 32'h0000_C002, 32'h0000_0000, 2'b00, 1'b1, 32'h007F_0000, 32'h0000_007F, 1'b0, 32'h0000_C000, 4'b0100, 32'h0000_0000, 3};

    reset = 1'b0; start = 1'b0; is_store = 1'b0; addr = '0; wdata = '0;
    mem_size = 2'b00; is_mem_sign = 1'b0; dmem_req_ready = 1'b1;
    dmem_resp_valid = 1'b1; dmem_resp_data = '0;
    #1;
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_valid", 32'(dmem_req_valid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_strb",  32'(dmem_req_wstrb), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Response valid held high throughout: it must be ignored outside WAIT.
    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Backpressure for 4 cycles, with a start pulse that must be ignored.
    @(negedge clock);
    is_store = 1'b0; addr = 32'h0000_D000; wdata = '0; mem_size = 2'b10;
    is_mem_sign = 1'b0; dmem_resp_data = 32'h0BAD_F00D; dmem_req_ready = 1'b0; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("bp%0d_valid", k), 32'(dmem_req_valid), 1);
      chk($sformatf("bp%0d_addr", k),  dmem_req_addr, 32'h0000_D000);
      chk($sformatf("bp%0d_wstrb", k), 32'(dmem_req_wstrb), 32'hF);
      chk($sformatf("bp%0d_wdata", k), dmem_req_wdata, 0);
      chk($sformatf("bp%0d_we", k),    32'(dmem_req_we), 0);
      chk($sformatf("bp%0d_done", k),  32'(done), 0);
      if (k == 1) begin
        start = 1'b1; is_store = 1'b1; addr = 32'h0000_E004; wdata = 32'hFFFF_FFFF;
      end
      if (k == 2) start = 1'b0;
    end
    dmem_req_ready = 1'b1;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 10) begin
      @(negedge clock); cyc++;
      if (done) got = 1'b1;
    end
    chk("bp_done_seen", 32'(got), 1);
    chk("bp_done_cycles", cyc, 2);
    chk("bp_rdata", rdata, 32'h0BAD_F00D);
    chk("bp_misaligned", 32'(misaligned), 0);
    @(negedge clock);
    chk("bp_idle", 32'(busy), 0);

    // Reset while a request is stalled in REQ.
    is_store = 1'b0; addr = 32'h0000_1003; mem_size = 2'b00; is_mem_sign = 1'b1;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    chk("rreq_valid_before", 32'(dmem_req_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("rreq_valid", 32'(dmem_req_valid), 0);
    chk("rreq_busy",  32'(busy), 0);
    chk("rreq_addr",  dmem_req_addr, 0);
    @(negedge clock);
    reset = 1'b1; dmem_req_ready = 1'b1;

    // Reset while waiting on the response; a late response must not finish it.
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rwait_busy_before",  32'(busy), 1);
    chk("rwait_valid_before", 32'(dmem_req_valid), 0);
    #2 reset = 1'b0;
    #1;
    chk("rwait_busy",  32'(busy), 0);
    chk("rwait_valid", 32'(dmem_req_valid), 0);
    chk("rwait_rdata", rdata, 0);
    chk("rwait_wdata", dmem_req_wdata, 0);
    chk("rwait_we",    32'(dmem_req_we), 0);
    @(negedge clock);
    reset = 1'b1; dmem_resp_valid = 1'b1; dmem_resp_data = 32'h8000_0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("late_resp%0d_done", k), 32'(done), 0);
      chk($sformatf("late_resp%0d_busy", k), 32'(busy), 0);
    end

    run_vec(vecs[4], "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter WORD_W, default 32, SHALL set data and address width.
REQ-002 Parameter STRB_W, default WORD_W/8, SHALL set the byte-strobe width.
REQ-003 Port clock, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: SHALL be the asynchronous, active-low reset.
REQ-005 Port start, input, 1: SHALL request one memory operation; sampled only in IDLE.
REQ-006 Port is_store, input, 1: SHALL select store (1) or load (0).
REQ-007 Port addr, input, WORD_W: SHALL carry the byte address (rs1+imm).
REQ-008 Port wdata, input, WORD_W: SHALL carry store data, right-aligned.
REQ-009 Port mem_size, input, 2: SHALL encode the access size as 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 Port is_mem_sign, input, 1: SHALL select a sign-extended (1) or zero-extended (0) load result.
REQ-011 Port busy, output, 1: SHALL be high in every state except IDLE.
REQ-012 Port done, output, 1: SHALL pulse for one cycle when an operation completes.
REQ-013 Port rdata, output, WORD_W: SHALL carry the extended load result.
REQ-014 Port misaligned, output, 1: SHALL be high together with done for a misaligned or illegal access.
REQ-015 Data-memory request ports SHALL be dmem_req_valid (out, 1), dmem_req_ready (in, 1), dmem_req_we (out, 1), dmem_req_addr (out, WORD_W), dmem_req_wdata (out, WORD_W) and dmem_req_wstrb (out, STRB_W).
REQ-016 Data-memory response ports SHALL be dmem_resp_valid (in, 1) and dmem_resp_data (in, WORD_W).

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT and DONE.
REQ-018 In IDLE with start=1, the block SHALL latch all operands; a legal access goes to REQ, and an illegal access goes to DONE with misaligned=1 and no bus activity.
REQ-019 An access SHALL be illegal when mem_size=11, when it is a half with addr[0]=1, or when it is a word with addr[1:0]!=0.
REQ-020 In REQ, dmem_req_valid SHALL be 1 and every request field SHALL stay stable until dmem_req_ready=1.
REQ-021 When the REQ handshake completes, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-022 dmem_req_addr SHALL be {addr[WORD_W-1:2],2'b00}.
REQ-023 dmem_req_wstrb SHALL be the size mask (0001, 0011 or 1111) shifted left by addr[1:0].
REQ-024 dmem_req_wdata SHALL be wdata shifted left by 8*addr[1:0].
REQ-025 dmem_req_we SHALL equal the latched is_store.
REQ-026 The response SHALL be accepted only in WAIT; dmem_resp_valid in any other state SHALL be ignored.
REQ-027 On acceptance, the block SHALL extract the byte lane or half lane at addr[1:0], extend it according to is_mem_sign, register it to rdata and go to DONE.
REQ-028 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 rdata and misaligned SHALL hold their values until the next done.
REQ-031 A store SHALL leave rdata unchanged.
REQ-032 Minimum load latency SHALL be 3 cycles from the start edge to done (with ready=1 and the response arriving the next cycle); minimum store latency SHALL be 2 cycles.

Reset
REQ-033 Reset assertion SHALL force state=IDLE asynchronously, from any state including mid-handshake.
REQ-034 During reset, busy, done, misaligned, dmem_req_valid and dmem_req_we SHALL be 0, and rdata, dmem_req_addr, dmem_req_wdata and dmem_req_wstrb SHALL be 0.
REQ-035 Reset release SHALL be followed by normal operation on the next rising edge.

Structure
REQ-036 The LSU state enum and the mem_size encodings SHALL live in the shared soc defines package alongside the existing opcode and funct3 constants.
REQ-037 Lane selection and extension SHALL be a combinational sub-module named lsu_align, reused for both the store shift and the load extraction.

Verification
REQ-038 LB sign: addr=0x1003, mem_size=00, is_mem_sign=1, resp_data=0x80FF_FFFF -> rdata=0xFFFF_FF80, misaligned=0, done 3 cycles after start.
REQ-039 LHU: addr=0x2002, mem_size=01, is_mem_sign=0, resp_data=0xBEEF_1234 -> rdata=0x0000_BEEF.
REQ-040 SB: addr=0x3001, wdata=0x0000_00AB -> dmem_req_addr=0x3000, dmem_req_wstrb=0010, dmem_req_wdata=0x0000_AB00, we=1, done 2 cycles after start.
REQ-041 Backpressure: dmem_req_ready held 0 for 4 cycles -> dmem_req_valid and all request fields stable for 4 cycles, then done follows.
REQ-042 Illegal access: LW at addr=0x4002 -> done=1 and misaligned=1 one cycle after start, dmem_req_valid never asserted.
REQ-043 Reset mid-operation: reset asserted while in WAIT -> busy=0 and dmem_req_valid=0 immediately, and a late dmem_resp_valid does not cause a done pulse.
